// File: rtl/computer_system_pio_capture.sv
// Parallel input port with synchroniser, edge capture and optional masked interrupt.
// Define PIO_CAPTURE_IRQ_EN to build the irqmask register and drive irq.
module computer_system_pio_capture #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + 2;

  typedef enum logic {ARMING, ARMED} arm_state_t;

  arm_state_t       arm_state, arm_state_next;
  logic [2:0]       arm_cnt, arm_cnt_next;
  logic             capture_en;

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] rise, fall, edges;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign wdata       = writedata[WIDTH-1:0];
  assign unused_bits = ^writedata;

  // Startup arming: edges are ignored until the reset-cleared chain has
  // flushed, so inputs already high at reset never look like edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      arm_state <= ARMING;
      arm_cnt   <= 3'd0;
    end else begin
      arm_state <= arm_state_next;
      arm_cnt   <= arm_cnt_next;
    end
  end

  always_comb begin
    arm_state_next = arm_state;
    arm_cnt_next   = arm_cnt;
    case (arm_state)
      ARMING: begin
        if (arm_cnt == 3'(ARM_CYCLES - 1)) arm_state_next = ARMED;
        else                               arm_cnt_next   = arm_cnt + 3'd1;
      end
      ARMED:   arm_state_next = ARMED;
      default: arm_state_next = ARMING;
    endcase
  end

  assign capture_en = (arm_state == ARMED);

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign data = in_port;
    end else begin : g_sync
      logic [WIDTH-1:0] chain [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
        end else begin
          chain[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
      end
      assign data = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) data_d <= '0;
    else          data_d <= data;
  end

  assign rise  = data & ~data_d;
  assign fall  = ~data & data_d;
  assign edges = (EDGE_TYPE == 0) ? rise :
                 (EDGE_TYPE == 1) ? fall : (rise | fall);

  assign clear_bits = (wr_en && address == 2'd3) ? wdata : '0;

  // Clear is applied before the new edges are ORed in, so a coinciding edge wins.
  always_ff @(posedge clk) begin
    if (!reset_n) edgecapture <= '0;
    else          edgecapture <= (edgecapture & ~clear_bits) |
                                 (capture_en ? edges : '0);
  end

`ifdef PIO_CAPTURE_IRQ_EN
  logic [WIDTH-1:0] irqmask;

  always_ff @(posedge clk) begin
    if (!reset_n)                     irqmask <= '0;
    else if (wr_en && address == 2'd2) irqmask <= wdata;
  end

  assign irq = |(edgecapture & irqmask);
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(data);
`ifdef PIO_CAPTURE_IRQ_EN
        2'd2:    readdata <= 32'(irqmask);
`endif
        2'd3:    readdata <= 32'(edgecapture);
        default: readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_computer_system_pio_capture.sv
// Bench for computer_system_pio_capture: directed table, corner sequences and
// randomized traffic against a cycle-level reference model on two configurations.
module tb_computer_system_pio_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  // dut1: defaults (WIDTH 4, 2 sync stages, rising)
  logic [1:0]  address1;
  logic        chipselect1, write_n1;
  logic [31:0] writedata1;
  logic [3:0]  in1;
  logic [31:0] readdata1;
  logic        irq1;
  // dut2: WIDTH 8, 1 sync stage, any edge
  logic [1:0]  address2;
  logic        chipselect2, write_n2;
  logic [31:0] writedata2;
  logic [7:0]  in2;
  logic [31:0] readdata2;
  logic        irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  computer_system_pio_capture dut1 (
    .clk(clk), .reset_n(reset_n), .address(address1), .chipselect(chipselect1),
    .write_n(write_n1), .writedata(writedata1), .in_port(in1),
    .readdata(readdata1), .irq(irq1)
  );

  computer_system_pio_capture #(.WIDTH(8), .SYNC_STAGES(1), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address2), .chipselect(chipselect2),
    .write_n(write_n2), .writedata(writedata2), .in_port(in2),
    .readdata(readdata2), .irq(irq2)
  );

`ifdef PIO_CAPTURE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // Reference model: p0 is the most recently sampled input, p1/p2 older samples.
  typedef struct {
    logic [31:0] p0, p1, p2, old, ec, mask, rd;
    int          since;
  } mstate_t;

  mstate_t m1, m2;

  function automatic mstate_t step(mstate_t s, int w, int st, int et, logic rn,
                                   logic [1:0] a, logic cs, logic wn,
                                   logic [31:0] wd, logic [31:0] inp);
    mstate_t n;
    logic [31:0] msk, data, rise, fall, edges, clr;
    logic wr;
    n   = s;
    msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (!rn) begin
      n.p0 = 0; n.p1 = 0; n.p2 = 0; n.old = 0; n.ec = 0; n.mask = 0; n.rd = 0;
      n.since = 0;
      return n;
    end
    data = (st == 0) ? (inp & msk) : (st == 1) ? s.p0 : (st == 2) ? s.p1 : s.p2;
    case (a)
      2'd0:    n.rd = data;
      2'd2:    n.rd = IRQ_EN ? s.mask : 32'd0;
      2'd3:    n.rd = s.ec;
      default: n.rd = 32'd0;
    endcase
    rise  = data & ~s.old;
    fall  = ~data & s.old & msk;
    edges = (et == 0) ? rise : (et == 1) ? fall : (rise | fall);
    wr    = cs && !wn;
    clr   = (wr && a == 2'd3) ? (wd & msk) : 32'd0;
    n.ec  = (s.ec & ~clr) | ((s.since >= st + 2) ? edges : 32'd0);
    if (IRQ_EN && wr && a == 2'd2) n.mask = wd & msk;
    n.old = data;
    n.p2  = s.p1;
    n.p1  = s.p0;
    n.p0  = inp & msk;
    if (s.since < 100) n.since = s.since + 1;
    return n;
  endfunction

  function automatic logic model_irq(mstate_t s);
    return IRQ_EN ? |(s.ec & s.mask) : 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m1 = step(m1, 4, 2, 0, reset_n, address1, chipselect1, write_n1, writedata1, 32'(in1));
    m2 = step(m2, 8, 1, 2, reset_n, address2, chipselect2, write_n2, writedata2, 32'(in2));
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic write1(logic [1:0] a, logic [31:0] d);
    address1 = a; chipselect1 = 1'b1; write_n1 = 1'b0; writedata1 = d;
    tick();
    chipselect1 = 1'b0; write_n1 = 1'b1;
  endtask

  task automatic write2(logic [1:0] a, logic [31:0] d);
    address2 = a; chipselect2 = 1'b1; write_n2 = 1'b0; writedata2 = d;
    tick();
    chipselect2 = 1'b0; write_n2 = 1'b1;
  endtask

  typedef struct {
    logic        rn;
    logic [1:0]  a;
    logic        cs, wn;
    logic [31:0] wd;
    logic [3:0]  inp;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rn, logic [1:0] a, logic cs, logic wn,
                             logic [31:0] wd, logic [3:0] inp, logic chk,
                             logic [31:0] exp_rd);
    vec_t r;
    r.rn = rn; r.a = a; r.cs = cs; r.wn = wn; r.wd = wd; r.inp = inp;
    r.chk = chk; r.exp_rd = exp_rd;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m1 = '{default: '0};
    m2 = '{default: '0};
    reset_n = 1'b0;
    address1 = 2'd0; chipselect1 = 1'b0; write_n1 = 1'b1; writedata1 = 32'd0; in1 = 4'h0;
    address2 = 2'd0; chipselect2 = 1'b0; write_n2 = 1'b1; writedata2 = 32'd0; in2 = 8'h00;

    // Each row is one clock; exp_rd is readdata after that clock's edge.
    vecs.push_back(v(0, 0, 0, 1, 0, 4'hA, 1, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 0, 4'hA, 1, 32'h0));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'hA, 1, 32'h0));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'hA, 1, 32'h0));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'hA, 1, 32'hA));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'hA, 0, 32'h0));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'hA, 0, 32'h0));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'hA, 1, 32'hA));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'hA, 1, 32'h0));
    vecs.push_back(v(1, 1, 1, 0, 32'hF, 4'hA, 1, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h0, 1, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h0, 0, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h0, 0, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h0, 1, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h5, 1, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h5, 1, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h5, 1, 32'h0));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h5, 1, 32'h5));
    vecs.push_back(v(1, 3, 1, 0, 32'h1, 4'h5, 1, 32'h5));
    vecs.push_back(v(1, 3, 0, 1, 0, 4'h5, 1, 32'h4));
    vecs.push_back(v(1, 0, 0, 1, 0, 4'h5, 1, 32'h5));
    vecs.push_back(v(1, 2, 0, 1, 0, 4'h5, 1, 32'h0));

    foreach (vecs[i]) begin
      reset_n = vecs[i].rn; address1 = vecs[i].a; chipselect1 = vecs[i].cs;
      write_n1 = vecs[i].wn; writedata1 = vecs[i].wd; in1 = vecs[i].inp;
      tick();
      if (vecs[i].chk) begin
        check($sformatf("table_rd[%0d]", i), readdata1, vecs[i].exp_rd);
        check($sformatf("table_irq[%0d]", i), 32'(irq1), 32'h0);
      end
    end
    chipselect1 = 1'b0; write_n1 = 1'b1;

    // Any-edge capture on WIDTH 8, clear, then clear coinciding with an edge.
    in2 = 8'h80; idle(4);
    in2 = 8'h00; idle(4);
    address2 = 2'd3; tick();
    check("w8_fall_bit7", readdata2, 32'h80);
    write2(2'd3, 32'hFFFF_FF80); tick();
    check("w8_cleared", readdata2, 32'h0);
    in2 = 8'h80; tick();
    write2(2'd3, 32'h80); tick();
    check("w8_edge_wins", readdata2, 32'h80);
    address2 = 2'd0; tick();
    check("w8_data", readdata2, 32'h80);
    check("w8_irq", 32'(irq2), 32'h0);

    // Interrupt masking.
    write1(2'd3, 32'hF);
    write1(2'd2, 32'h2);
    address1 = 2'd2; tick();
    check("irqmask_read", readdata1, IRQ_EN ? 32'h2 : 32'h0);
    in1 = 4'h4; idle(4);
    in1 = 4'h5; idle(4);
    check("irq_bit0_masked", 32'(irq1), 32'h0);
    address1 = 2'd3; tick();
    check("ec_bit0", readdata1, 32'h1);
    in1 = 4'h7; idle(4);
    check("irq_bit1", 32'(irq1), IRQ_EN ? 32'h1 : 32'h0);
    idle(2);
    check("irq_bit1_held", 32'(irq1), IRQ_EN ? 32'h1 : 32'h0);
    tick();
    check("ec_bits01", readdata1, 32'h3);
    write1(2'd3, 32'h2); tick();
    check("irq_cleared", 32'(irq1), 32'h0);
    check("ec_after_clear", readdata1, 32'h1);

    // Mid-operation reset discards captures and re-arms.
    write1(2'd3, 32'hF);
    in1 = 4'h0; idle(4);
    in1 = 4'hF; idle(4);
    address1 = 2'd3; tick();
    check("ec_all", readdata1, 32'hF);
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    check("rst_rd", readdata1, 32'h0);
    check("rst_irq", 32'(irq1), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rearm_ec[%0d]", i), readdata1, 32'h0);
    end
    address1 = 2'd0; tick();
    check("rearm_data", readdata1, 32'hF);
    address1 = 2'd2; tick();
    check("rearm_mask", readdata1, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      reset_n     = ($urandom_range(0, 149) != 0);
      address1    = 2'($urandom_range(0, 3));
      chipselect1 = 1'($urandom_range(0, 1));
      write_n1    = ($urandom_range(0, 3) != 0);
      writedata1  = $urandom;
      if ($urandom_range(0, 3) == 0) in1 = 4'($urandom);
      address2    = 2'($urandom_range(0, 3));
      chipselect2 = 1'($urandom_range(0, 1));
      write_n2    = ($urandom_range(0, 3) != 0);
      writedata2  = $urandom;
      if ($urandom_range(0, 3) == 0) in2 = 8'($urandom);
      tick();
      check("rand_rd1", readdata1, m1.rd);
      check("rand_irq1", 32'(irq1), 32'(model_irq(m1)));
      check("rand_rd2", readdata2, m2.rd);
      check("rand_irq2", 32'(irq2), 32'(model_irq(m2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
